// File: rtl/prog3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog3_pkg
//  Description : Shared defaults and state encoding for the 5-bit pattern
//                scan engine.
//                Address/size defaults : c_pat_addr_def, c_res_base_def,
//                                        c_str_bytes_def
//                State typedef         : state_t
//  Revision    : 1.0  initial release
// ============================================================================
package prog3_pkg;

    localparam int c_pat_addr_def  = 32;
    localparam int c_res_base_def  = 33;
    localparam int c_str_bytes_def = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_PAT = 3'd1,
        RD_STR = 3'd2,
        WR_CTB = 3'd3,
        WR_CTO = 3'd4,
        WR_CTS = 3'd5,
        DONE   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pat_window_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : pat_window_cmp
//  Description : Combinational 5-bit window matcher for one string byte.
//                prev      : previous byte (more significant in the string)
//                cur       : current byte
//                pat       : 5-bit pattern
//                first     : cur is the first byte (no crossing windows)
//                in_cnt    : matches among the four windows inside cur
//                any_hit   : in_cnt is non-zero
//                cross_cnt : matches among the four windows spanning prev|cur
//  Revision    : 1.0  initial release
// ============================================================================
module pat_window_cmp (
    input  logic [7:0] prev,
    input  logic [7:0] cur,
    input  logic [4:0] pat,
    input  logic       first,
    output logic [2:0] in_cnt,
    output logic       any_hit,
    output logic [2:0] cross_cnt
);

    logic [15:0] w_cat;
    assign w_cat = {prev, cur};

    always_comb begin
        in_cnt    = 3'd0;
        cross_cnt = 3'd0;
        // In-byte windows b[4:0] .. b[7:3]
        for (int i = 0; i < 4; i++) begin
            if (cur[i +: 5] == pat) begin
                in_cnt = in_cnt + 3'd1;
            end
        end
        // Crossing windows {p[3:0],c[7]} .. {p[0],c[7:4]} sit at cat[11:7] .. cat[8:4]
        for (int i = 4; i < 8; i++) begin
            if (w_cat[i +: 5] == pat) begin
                cross_cnt = cross_cnt + 3'd1;
            end
        end
        if (first) begin
            cross_cnt = 3'd0;
        end
        any_hit = (in_cnt != 3'd0);
    end

endmodule
`default_nettype wire

// File: rtl/pat_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pat_scan_engine
//  Description : Counts occurrences of a 5-bit pattern in a byte string held
//                in data memory and writes three counts back to memory.
//                clk         : clock
//                reset       : synchronous active-high reset
//                start       : one-cycle scan request (IDLE/DONE only)
//                mem_addr    : memory address (registered)
//                mem_rd_data : read data, one cycle after mem_addr
//                mem_wr_en   : write strobe (registered)
//                mem_wr_data : write data (registered)
//                done        : results written, held until start/reset
//  Revision    : 1.0  initial release
// ============================================================================
module pat_scan_engine
    import prog3_pkg::*;
#(
    parameter int PAT_ADDR  = c_pat_addr_def,
    parameter int RES_BASE  = c_res_base_def,
    parameter int STR_BYTES = c_str_bytes_def
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    output logic       done
);

    state_t     r_state;
    logic [4:0] r_pat;
    logic [7:0] r_prev;
    logic       r_first;
    logic [7:0] r_ctb;
    logic [7:0] r_cto;
    logic [7:0] r_cts;
    logic [7:0] r_idx;
    logic       r_rd_active;   // a string address is on mem_addr this cycle
    logic       r_str_pend;    // string byte is on mem_rd_data this cycle
    logic       r_pat_pend;    // pattern byte is on mem_rd_data this cycle

    logic [2:0] w_in_cnt;
    logic [2:0] w_cross_cnt;
    logic       w_any_hit;
    logic [7:0] w_ctb_nxt;
    logic [7:0] w_cto_nxt;
    logic [7:0] w_cts_nxt;
    logic       w_last;

    pat_window_cmp u_cmp (
        .prev      (r_prev),
        .cur       (mem_rd_data),
        .pat       (r_pat),
        .first     (r_first),
        .in_cnt    (w_in_cnt),
        .any_hit   (w_any_hit),
        .cross_cnt (w_cross_cnt)
    );

    assign w_ctb_nxt = r_ctb + {5'd0, w_in_cnt};
    assign w_cto_nxt = r_cto + {7'd0, w_any_hit};
    assign w_cts_nxt = r_cts + {5'd0, w_in_cnt} + {5'd0, w_cross_cnt};
    // Last byte is arriving and no further reads are outstanding
    assign w_last    = r_str_pend && !r_rd_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pat       <= 5'd0;
            r_prev      <= 8'd0;
            r_first     <= 1'b1;
            r_ctb       <= 8'd0;
            r_cto       <= 8'd0;
            r_cts       <= 8'd0;
            r_idx       <= 8'd0;
            r_rd_active <= 1'b0;
            r_str_pend  <= 1'b0;
            r_pat_pend  <= 1'b0;
            mem_addr    <= 8'd0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            done        <= 1'b0;
        end else begin
            r_pat_pend <= 1'b0;
            r_str_pend <= r_rd_active;

            if (r_pat_pend) begin
                r_pat <= mem_rd_data[7:3];
            end
            if (r_str_pend) begin
                r_ctb   <= w_ctb_nxt;
                r_cto   <= w_cto_nxt;
                r_cts   <= w_cts_nxt;
                r_prev  <= mem_rd_data;
                r_first <= 1'b0;
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= RD_PAT;
                        mem_addr <= 8'(PAT_ADDR);
                        done     <= 1'b0;
                        r_ctb    <= 8'd0;
                        r_cto    <= 8'd0;
                        r_cts    <= 8'd0;
                        r_pat    <= 5'd0;
                        r_prev   <= 8'd0;
                        r_first  <= 1'b1;
                    end
                end
                RD_PAT: begin
                    r_state     <= RD_STR;
                    mem_addr    <= 8'd0;
                    r_idx       <= 8'd0;
                    r_rd_active <= 1'b1;
                    r_pat_pend  <= 1'b1;
                end
                RD_STR: begin
                    if (r_rd_active) begin
                        if (r_idx == 8'(STR_BYTES - 1)) begin
                            r_rd_active <= 1'b0;
                        end else begin
                            r_idx    <= r_idx + 8'd1;
                            mem_addr <= r_idx + 8'd1;
                        end
                    end
                    // Final count folds in the byte arriving now
                    if (w_last) begin
                        r_state     <= WR_CTB;
                        mem_addr    <= 8'(RES_BASE);
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= w_ctb_nxt;
                    end
                end
                WR_CTB: begin
                    r_state     <= WR_CTO;
                    mem_addr    <= 8'(RES_BASE + 1);
                    mem_wr_data <= r_cto;
                end
                WR_CTO: begin
                    r_state     <= WR_CTS;
                    mem_addr    <= 8'(RES_BASE + 2);
                    mem_wr_data <= r_cts;
                end
                WR_CTS: begin
                    r_state     <= DONE;
                    mem_addr    <= 8'd0;
                    mem_wr_en   <= 1'b0;
                    mem_wr_data <= 8'd0;
                    done        <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pat_scan_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pat_scan_engine
//  Description : Directed vector bench for pat_scan_engine with a behavioural
//                1-cycle-latency memory.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pat_scan_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic       done;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    int addr_log [64];
    int done_log [64];
    int res [3];

    typedef struct {
        logic [7:0] pat;
        logic [7:0] even_b;
        logic [7:0] odd_b;
        int         ctb;
        int         cto;
        int         cts;
    } vec_t;

    vec_t vecs [6];

    pat_scan_engine #(
        .PAT_ADDR  (32),
        .RES_BASE  (33),
        .STR_BYTES (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[32] = v.pat;
        for (int i = 0; i < 32; i++) mem[i] = (i % 2 == 0) ? v.even_b : v.odd_b;
    endtask

    // Pulses start in cycle 0, then observes cycles 1..60.
    task automatic scan(input int restart_at, input int reset_at,
                        output int done_cyc, output int first_wr, output int n_wr);
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        done_cyc = -1;
        first_wr = -1;
        n_wr     = 0;
        for (int i = 0; i < 3; i++) res[i] = -1;
        for (int k = 1; k <= 60; k++) begin
            addr_log[k] = int'(mem_addr);
            done_log[k] = int'(done);
            if (mem_wr_en) begin
                if (first_wr < 0) first_wr = k;
                n_wr++;
                if (mem_addr >= 8'd33 && mem_addr <= 8'd35)
                    res[int'(mem_addr) - 33] = int'(mem_wr_data);
            end
            if (done && done_cyc < 0) done_cyc = k;
            start = (k == restart_at);
            reset = (k == reset_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int dc, fw, nw;

        vecs[0] = '{8'hA8, 8'h57, 8'h57,  32, 32,  63};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 128, 32, 252};
        vecs[2] = '{8'hA8, 8'h55, 8'h55,  64, 32, 126};
        vecs[3] = '{8'hF8, 8'h00, 8'h00,   0,  0,   0};
        vecs[4] = '{8'hF8, 8'h0F, 8'hF0,   0,  0,  64};
        vecs[5] = '{8'hF8, 8'hFF, 8'hFF, 128, 32, 252};

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(mem_wr_en), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_wr_data", int'(mem_wr_data), 0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", int'(done), 0);

        foreach (vecs[v]) begin
            load(vecs[v]);
            scan(0, 0, dc, fw, nw);
            chk($sformatf("v%0d_ctb", v), res[0], vecs[v].ctb);
            chk($sformatf("v%0d_cto", v), res[1], vecs[v].cto);
            chk($sformatf("v%0d_cts", v), res[2], vecs[v].cts);
            chk($sformatf("v%0d_done_cyc", v), dc, 38);
            chk($sformatf("v%0d_first_wr", v), fw, 35);
            chk($sformatf("v%0d_n_wr", v), nw, 3);
            if (v == 0) begin
                chk("addr_c1", addr_log[1], 32);
                chk("addr_c2", addr_log[2], 0);
                chk("addr_c33", addr_log[33], 31);
                chk("addr_c35", addr_log[35], 33);
                chk("done_c37", done_log[37], 0);
            end
        end

        // Reset in the middle of a scan aborts it
        load(vecs[0]);
        scan(0, 20, dc, fw, nw);
        chk("abort_n_wr", nw, 0);
        chk("abort_done_cyc", dc, -1);
        chk("abort_addr_c21", addr_log[21], 0);

        // Following scan runs cleanly
        load(vecs[2]);
        scan(0, 0, dc, fw, nw);
        chk("post_abort_ctb", res[0], 64);
        chk("post_abort_cts", res[2], 126);
        chk("post_abort_done_cyc", dc, 38);

        // start during RD_STR is ignored
        load(vecs[0]);
        scan(10, 0, dc, fw, nw);
        chk("restart_ctb", res[0], 32);
        chk("restart_cto", res[1], 32);
        chk("restart_cts", res[2], 63);
        chk("restart_done_cyc", dc, 38);
        chk("restart_n_wr", nw, 3);

        // start from DONE: done drops immediately and rescan completes
        chk("in_done", int'(done), 1);
        scan(0, 0, dc, fw, nw);
        chk("rescan_done_c1", done_log[1], 0);
        chk("rescan_cts", res[2], 63);
        chk("rescan_done_cyc", dc, 38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
